abz_index_ctrl: RTL

Quadrature ABZ encoder controller. Synchronises raw A/B/Z, decodes x4 quadrature into a signed-agnostic position counter, and sequences the homing procedure (seek index, capture, zero). After homing it checks every index pulse against the expected counts-per-revolution. It sits between the encoder pins and the register/host interface of the encoder detector.

---
 rtl/abz_index_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/abz_index_ctrl.sv
// Quadrature ABZ encoder controller: input synchronisation, x4 decode into a
// wrapping position counter, and the homing sequencer (seek index, capture,
// zero) with index-placement and seek-timeout checking once homed.
// Optional build macro: ABZ_DIGITAL_FILTER_EN adds a per-input stability
// filter of FILT_LEN cycles between the synchronisers and the decoder.
module abz_index_ctrl #(
    parameter int CNT_W    = 32,
    parameter int CPR_LOG2 = 12,
    parameter int FILT_LEN = 4
) (
    input  logic             CLK,
    input  logic             ARSTN,
    input  logic             A,
    input  logic             B,
    input  logic             Z,
    input  logic             CMD_HOME,
    input  logic             CMD_ABORT,
    input  logic             CLR_ERR,
    output logic [CNT_W-1:0] POSITION,
    output logic             DIR,
    output logic             BUSY,
    output logic             HOMED,
    output logic [CNT_W-1:0] IDX_CAPT,
    output logic             IDX_VALID,
    output logic             QERR,
    output logic             IDX_ERR
);

    // Startup window long enough for the slowest (filtered) input path to hold real pin levels.
    localparam int INIT_CYC = 3 + FILT_LEN;
    localparam int INIT_W   = $clog2(INIT_CYC + 1);
    localparam int SEEK_W   = CPR_LOG2 + 2;
    localparam logic [SEEK_W-1:0]   SEEK_LIMIT = {2'b10, {CPR_LOG2{1'b0}}};
    localparam logic [CPR_LOG2-1:0] CPR_M1     = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEEK, ST_DONE} state_t;

    logic [2:0]          meta_q, sync_q, clean;
    logic [1:0]          ab_prev_q, ab_prev_d, ab_cur, dphase;
    logic                z_prev_q, z_prev_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic                ready, step_fwd, step_rev, illegal, z_rise;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    pos_q, pos_d, pos_step, capt_q, capt_d;
    logic [SEEK_W-1:0]   seek_cnt_q, seek_cnt_d;
    logic                dir_q, dir_d, homed_q, homed_d, idx_valid_q, idx_valid_d;
    logic                qerr_q, qerr_d, idx_err_q, idx_err_d, idx_err_set, home_go;
    logic [CPR_LOG2-1:0] low_bits;

    // Two-flop synchroniser for the asynchronous encoder pins, ordered {A,B,Z}.
    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {A, B, Z};
            sync_q <= meta_q;
        end
    end

`ifdef ABZ_DIGITAL_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);
    logic [2:0]           filt_q, filt_d;
    logic [2:0][FC_W-1:0] fcnt_q, fcnt_d;

    // Each filtered input follows its synced value only after FILT_LEN consecutive disagreeing cycles.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FC_W'(FILT_LEN - 1)) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FC_W'(1);
                end
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign clean = filt_q;
`else
    assign clean = sync_q;
`endif

    // Gray phase index of an AB pair along the forward sequence 00,01,11,10.
    function automatic logic [1:0] phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   phase_of = 2'd0;
            2'b01:   phase_of = 2'd1;
            2'b11:   phase_of = 2'd2;
            default: phase_of = 2'd3;
        endcase
    endfunction

    assign ready    = (init_cnt_q == INIT_W'(INIT_CYC));
    assign ab_cur   = clean[2:1];
    assign dphase   = phase_of(ab_cur) - phase_of(ab_prev_q);
    assign step_fwd = ready && (dphase == 2'd1);
    assign step_rev = ready && (dphase == 2'd3);
    assign illegal  = ready && (dphase == 2'd2);
    assign z_rise   = ready && clean[0] && !z_prev_q;
    assign home_go  = CMD_HOME && !CMD_ABORT;
    assign low_bits = pos_step[CPR_LOG2-1:0];

    // Decode, position counting, homing sequencer and sticky error flags.
    always_comb begin
        init_cnt_d  = ready ? init_cnt_q : init_cnt_q + INIT_W'(1);
        ab_prev_d   = ab_cur;
        z_prev_d    = clean[0];
        state_d     = state_q;
        pos_step    = pos_q;
        if (step_fwd) pos_step = pos_q + CNT_W'(1);
        if (step_rev) pos_step = pos_q - CNT_W'(1);
        pos_d       = pos_step;
        dir_d       = dir_q;
        if (step_fwd) dir_d = 1'b1;
        if (step_rev) dir_d = 1'b0;
        homed_d     = homed_q;
        capt_d      = capt_q;
        idx_valid_d = 1'b0;
        seek_cnt_d  = seek_cnt_q;
        idx_err_set = 1'b0;
        qerr_d      = (CLR_ERR ? 1'b0 : qerr_q) | illegal;

        case (state_q)
            ST_IDLE: begin
                if (home_go) begin
                    state_d    = ST_SEEK;
                    homed_d    = 1'b0;
                    seek_cnt_d = '0;
                end
            end
            ST_SEEK: begin
                if (CMD_ABORT) begin
                    state_d = ST_IDLE;
                    homed_d = 1'b0;
                end else if (z_rise) begin
                    capt_d      = pos_step;
                    pos_d       = '0;
                    idx_valid_d = 1'b1;
                    homed_d     = 1'b1;
                    state_d     = ST_DONE;
                end else if (step_fwd || step_rev) begin
                    if (seek_cnt_q + SEEK_W'(1) == SEEK_LIMIT) begin
                        idx_err_set = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        seek_cnt_d = seek_cnt_q + SEEK_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (z_rise) begin
                    capt_d      = pos_step;
                    idx_valid_d = 1'b1;
                    if (!(low_bits == '0 || low_bits == CPR_LOG2'(1) || low_bits == CPR_M1)) begin
                        idx_err_set = 1'b1;
                    end
                end
                if (home_go) begin
                    state_d    = ST_SEEK;
                    homed_d    = 1'b0;
                    seek_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        idx_err_d = (CLR_ERR ? 1'b0 : idx_err_q) | idx_err_set;
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            init_cnt_q  <= '0;
            ab_prev_q   <= '0;
            z_prev_q    <= 1'b0;
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            homed_q     <= 1'b0;
            capt_q      <= '0;
            idx_valid_q <= 1'b0;
            seek_cnt_q  <= '0;
            qerr_q      <= 1'b0;
            idx_err_q   <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            ab_prev_q   <= ab_prev_d;
            z_prev_q    <= z_prev_d;
            state_q     <= state_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            homed_q     <= homed_d;
            capt_q      <= capt_d;
            idx_valid_q <= idx_valid_d;
            seek_cnt_q  <= seek_cnt_d;
            qerr_q      <= qerr_d;
            idx_err_q   <= idx_err_d;
        end
    end

    assign POSITION  = pos_q;
    assign DIR       = dir_q;
    assign BUSY      = (state_q == ST_SEEK);
    assign HOMED     = homed_q;
    assign IDX_CAPT  = capt_q;
    assign IDX_VALID = idx_valid_q;
    assign QERR      = qerr_q;
    assign IDX_ERR   = idx_err_q;

endmodule
